dense_layer_seq: RTL and testbench

- Fully connected layer that consumes the flattened feature vector (4 feature maps × 5×5 = 100 words, map-interleaved order) and produces N_OUT neuron outputs.
- Sequential: one multiply-accumulate per clock.
- Weights are fetched from an external weight memory through a synchronous read port. Biases arrive as a parallel array.
- Sits directly downstream of the flatten stage and upstream of the classifier/argmax stage.

---
 rtl/dense_layer_seq_if.sv | 38 +++
 rtl/dense_layer_seq.sv | 185 ++++++++++++++++++
 tb/tb_dense_layer_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_seq_if.sv
// Control and weight-memory bus of the sequential dense layer.
// The layer side uses the master modport, the environment and weight memory the slave modport.
interface dense_layer_seq_if #(
  parameter int WIDTH_BIT = 32,
  parameter int ADDR_W    = 10
);
  // Handshake: start is a request that is honoured only while the layer is idle (busy=0);
  // there is no ready/ack. weight_data must carry mem[weight_addr] exactly one clock
  // after a cycle with weight_rd_en=1. done pulses once per inference; out_valid then
  // holds until the next start is accepted.
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        out_valid;
  logic                        weight_rd_en;
  logic [ADDR_W-1:0]           weight_addr;
  logic signed [WIDTH_BIT-1:0] weight_data;

  modport master (
    input  start,
    input  weight_data,
    output busy,
    output done,
    output out_valid,
    output weight_rd_en,
    output weight_addr
  );

  modport slave (
    output start,
    output weight_data,
    input  busy,
    input  done,
    input  out_valid,
    input  weight_rd_en,
    input  weight_addr
  );
endinterface

// File: rtl/dense_layer_seq.sv
// Fully connected layer, one signed MAC per clock, weights from a 1-cycle-latency memory.
// Optional macro DENSE_RELU_EN clamps negative neuron results to zero before writing them.
module dense_layer_seq #(
  parameter int WIDTH_BIT = 32,
  parameter int N_IN      = 100,
  parameter int N_OUT     = 10,
  parameter int FRAC_BITS = 16,
  parameter int ACC_WIDTH = 2*WIDTH_BIT+8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dense_layer_seq_if.master           bus,
  input  logic signed [WIDTH_BIT-1:0] flattenIn [N_IN],
  input  logic signed [WIDTH_BIT-1:0] biasIn    [N_OUT],
  output logic signed [WIDTH_BIT-1:0] denseOut  [N_OUT],
  output logic [2:0]                  dbg_state
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int AW = (N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(N_IN-1);
  localparam logic [OW-1:0] LAST_O = OW'(N_OUT-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH_BIT+1){1'b1}}, {(WIDTH_BIT-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [OW-1:0]                 o_q, o_d;
  logic [AW-1:0]                 addr_q, addr_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [WIDTH_BIT-1:0]   data_q  [N_IN];
  logic signed [WIDTH_BIT-1:0]   data_d  [N_IN];
  logic signed [WIDTH_BIT-1:0]   dense_q [N_OUT];
  logic signed [WIDTH_BIT-1:0]   dense_d [N_OUT];

  logic                          accept;
  logic                          mac_en;
  logic [IW-1:0]                 mac_idx;
  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [ACC_WIDTH-1:0]   scaled;
  logic signed [WIDTH_BIT-1:0]   sat_val;
  logic signed [WIDTH_BIT-1:0]   wr_val;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_MAC;
      S_MAC:   if (i_q == LAST_I) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (o_q == LAST_O) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so that reset clears them without waiting for a clock
  always_comb begin
    bus.weight_rd_en = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    case (state_q)
      S_MAC: begin
        bus.weight_rd_en = 1'b1;
        bus.busy         = 1'b1;
      end
      S_DRAIN, S_WRITE: bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
    bus.weight_addr = (state_q == S_MAC) ? addr_q : '0;
    bus.out_valid   = out_valid_q;
    dbg_state       = state_q;
  end

  // Datapath: the product of the previous read is folded in one cycle after its address
  always_comb begin
    accept   = (state_q == S_IDLE) && bus.start;
    mac_en   = ((state_q == S_MAC) && (i_q != '0)) || (state_q == S_DRAIN);
    mac_idx  = (state_q == S_DRAIN) ? LAST_I : (i_q - IW'(1));
    prod     = data_q[mac_idx] * bus.weight_data;
    prod_ext = {{(ACC_WIDTH-2*WIDTH_BIT){prod[2*WIDTH_BIT-1]}}, prod};
    bias_ext = {{(ACC_WIDTH-WIDTH_BIT){biasIn[o_q][WIDTH_BIT-1]}}, biasIn[o_q]};
    sum      = acc_q + (bias_ext <<< FRAC_BITS);
    scaled   = sum >>> FRAC_BITS;

    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[WIDTH_BIT-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[WIDTH_BIT-1:0];
    end else begin
      sat_val = scaled[WIDTH_BIT-1:0];
    end

`ifdef DENSE_RELU_EN
    wr_val = sat_val[WIDTH_BIT-1] ? '0 : sat_val;
`else
    wr_val = sat_val;
`endif

    i_d         = i_q;
    o_d         = o_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    dense_d     = dense_q;

    if (accept) begin
      data_d      = flattenIn;
      i_d         = '0;
      o_d         = '0;
      addr_d      = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end

    if (mac_en) begin
      acc_d = acc_q + prod_ext;
    end

    if (state_q == S_MAC) begin
      addr_d = addr_q + AW'(1);
      if (i_q != LAST_I) i_d = i_q + IW'(1);
    end

    if (state_q == S_WRITE) begin
      dense_d[o_q] = wr_val;
      acc_d        = '0;
      i_d          = '0;
      if (o_q == LAST_O) begin
        out_valid_d = 1'b1;
      end else begin
        o_d = o_q + OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q         <= '0;
      o_q         <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < N_IN; k++)  data_q[k]  <= '0;
      for (int k = 0; k < N_OUT; k++) dense_q[k] <= '0;
    end else begin
      i_q         <= i_d;
      o_q         <= o_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      dense_q     <= dense_d;
    end
  end

  assign denseOut = dense_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: three small instances (32b integer, 8b saturating, 32b Q16.16)
// driven from a vector table, hand-written timing sequences and randomized runs.
module tb_dense_layer_seq;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int NW = NI*NO;
  localparam int AW = 3;

`ifdef DENSE_RELU_EN
  localparam logic signed [31:0] NEG128 = 32'sd0;
  localparam logic signed [31:0] NEG27  = 32'sd0;
`else
  localparam logic signed [31:0] NEG128 = -32'sd128;
  localparam logic signed [31:0] NEG27  = -32'sd27;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- stimulus storage, index = instance ----------------
  logic signed [31:0] flat [3][NI];
  logic signed [31:0] bias [3][NO];
  logic signed [31:0] wmem [3][NW];
  logic               start [3];
  int                 rd_log [$];
  logic [31:0]        exp_q [$];

  logic signed [31:0] f0 [NI], f2 [NI], b0 [NO], b2 [NO], d0 [NO], d2 [NO];
  logic signed [7:0]  f1 [NI], b1 [NO], d1 [NO];
  logic [2:0]         dbg0, dbg1, dbg2;

  for (genvar k = 0; k < NI; k++) begin : g_f
    assign f0[k] = flat[0][k];
    assign f1[k] = flat[1][k][7:0];
    assign f2[k] = flat[2][k];
  end
  for (genvar k = 0; k < NO; k++) begin : g_b
    assign b0[k] = bias[0][k];
    assign b1[k] = bias[1][k][7:0];
    assign b2[k] = bias[2][k];
  end

  dense_layer_seq_if #(.WIDTH_BIT(32), .ADDR_W(AW)) bus0 ();
  dense_layer_seq_if #(.WIDTH_BIT(8),  .ADDR_W(AW)) bus1 ();
  dense_layer_seq_if #(.WIDTH_BIT(32), .ADDR_W(AW)) bus2 ();

  assign bus0.start = start[0];
  assign bus1.start = start[1];
  assign bus2.start = start[2];

  // weight memories, one-cycle read latency
  always @(posedge clk) begin
    if (bus0.weight_rd_en) bus0.weight_data <= wmem[0][bus0.weight_addr];
    if (bus1.weight_rd_en) bus1.weight_data <= wmem[1][bus1.weight_addr][7:0];
    if (bus2.weight_rd_en) bus2.weight_data <= wmem[2][bus2.weight_addr];
  end

  dense_layer_seq #(.WIDTH_BIT(32), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .flattenIn(f0), .biasIn(b0),
    .denseOut(d0), .dbg_state(dbg0));
  dense_layer_seq #(.WIDTH_BIT(8), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .flattenIn(f1), .biasIn(b1),
    .denseOut(d1), .dbg_state(dbg1));
  dense_layer_seq #(.WIDTH_BIT(32), .N_IN(NI), .N_OUT(NO), .FRAC_BITS(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .flattenIn(f2), .biasIn(b2),
    .denseOut(d2), .dbg_state(dbg2));

  // ---------------- accessors ----------------
  function automatic logic signed [31:0] get_out(int d, int o);
    case (d)
      0:       return d0[o];
      1:       return {{24{d1[o][7]}}, d1[o]};
      default: return d2[o];
    endcase
  endfunction

  function automatic logic get_done(int d);
    case (d)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  function automatic logic get_ov(int d);
    case (d)
      0:       return bus0.out_valid;
      1:       return bus1.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  function automatic logic get_rd(int d);
    case (d)
      0:       return bus0.weight_rd_en;
      1:       return bus1.weight_rd_en;
      default: return bus2.weight_rd_en;
    endcase
  endfunction

  function automatic int get_addr(int d);
    case (d)
      0:       return int'(bus0.weight_addr);
      1:       return int'(bus1.weight_addr);
      default: return int'(bus2.weight_addr);
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] sx(logic signed [31:0] v, int w);
    logic signed [7:0] b8;
    b8 = v[7:0];
    return (w == 8) ? {{120{b8[7]}}, b8} : {{96{v[31]}}, v};
  endfunction

  // neuron o = floor((sum_i x_i*w_{o,i} + b_o*2^F) / 2^F), clamped to the word range
  function automatic logic signed [31:0] model(int d, int o);
    int w  = (d == 1) ? 8 : 32;
    int fr = (d == 2) ? 16 : 0;
    logic signed [127:0] acc, mx, mn;
    acc = '0;
    for (int i = 0; i < NI; i++) acc += sx(flat[d][i], w) * sx(wmem[d][o*NI+i], w);
    acc += sx(bias[d][o], w) <<< fr;
    acc = acc >>> fr;
    mx = (128'sd1 <<< (w-1)) - 128'sd1;
    mn = -(128'sd1 <<< (w-1));
    if (acc > mx) acc = mx;
    if (acc < mn) acc = mn;
`ifdef DENSE_RELU_EN
    if (acc < 0) acc = '0;
`endif
    return acc[31:0];
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]            d;
    logic [NI-1:0][31:0]   f;
    logic [NW-1:0][31:0]   w;
    logic [NO-1:0][31:0]   b;
    logic [NO-1:0][31:0]   e;
  } vec_t;

  vec_t tbl [5];

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load(input int k);
    int d = int'(tbl[k].d);
    for (int i = 0; i < NI; i++) flat[d][i] = tbl[k].f[i];
    for (int i = 0; i < NW; i++) wmem[d][i] = tbl[k].w[i];
    for (int i = 0; i < NO; i++) bias[d][i] = tbl[k].b[i];
  endtask

  // Accept edge is cycle 0; negedge n samples cycle n. Optional re-pulse of start with new data.
  task automatic run(input int d, input int repulse, output int done_cyc, output int n_done);
    done_cyc = -1;
    n_done   = 0;
    rd_log.delete();
    @(negedge clk);
    start[d] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (get_rd(d)) rd_log.push_back(n*16 + get_addr(d));
      if (get_done(d)) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (n == repulse) begin
        for (int i = 0; i < NI; i++) flat[d][i] = $urandom;
        start[d] = 1'b1;
      end else begin
        start[d] = 1'b0;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(bus0.busy), 0);
    check({tag, "_done"},  32'(bus0.done), 0);
    check({tag, "_ov"},    32'(bus0.out_valid), 0);
    check({tag, "_rd_en"}, 32'(bus0.weight_rd_en), 0);
    check({tag, "_out0"},  d0[0], 0);
    check({tag, "_out1"},  d0[1], 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dc, nd, first, second, cyc, d;

    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      for (int i = 0; i < NI; i++) flat[k][i] = '0;
      for (int i = 0; i < NO; i++) bias[k][i] = '0;
      for (int i = 0; i < NW; i++) wmem[k][i] = '0;
    end

    tbl[0].d = 2'd0;
    tbl[0].f = {32'sd4, 32'sd3, 32'sd2, 32'sd1};
    tbl[0].w = {32'sd3, -32'sd1, 32'sd0, 32'sd2, 32'sd1, 32'sd1, 32'sd1, 32'sd1};
    tbl[0].b = {-32'sd2, 32'sd5};
    tbl[0].e = {32'sd9, 32'sd15};
    tbl[1].d = 2'd1;
    tbl[1].f = {NI{32'sd127}};
    tbl[1].w = {NW{32'sd127}};
    tbl[1].b = '0;
    tbl[1].e = {NO{32'sd127}};
    tbl[2].d = 2'd1;
    tbl[2].f = {NI{32'sd127}};
    tbl[2].w = {NW{-32'sd128}};
    tbl[2].b = '0;
    tbl[2].e = {NO{NEG128}};
    tbl[3].d = 2'd2;
    tbl[3].f = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_8000};
    tbl[3].w = {{(NW-1){32'h0}}, 32'h0002_0000};
    tbl[3].b = {32'h0, 32'h0001_0000};
    tbl[3].e = {32'h0, 32'h0004_0000};
    tbl[4].d = 2'd0;
    tbl[4].f = {-32'sd1, 32'sd0, 32'sd7, -32'sd3};
    tbl[4].w = {-32'sd1, -32'sd1, -32'sd1, -32'sd1, 32'sd1, 32'sd5, -32'sd2, 32'sd4};
    tbl[4].b = {32'sd100, 32'sd0};
    tbl[4].e = {32'sd97, NEG27};

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // table-driven vectors
    for (int k = 0; k < 5; k++) begin
      load(k);
      d = int'(tbl[k].d);
      run(d, 0, dc, nd);
      check($sformatf("vec%0d_done_cycle", k), dc, 13);
      check($sformatf("vec%0d_done_count", k), nd, 1);
      check($sformatf("vec%0d_out_valid", k), 32'(get_ov(d)), 1);
      for (int o = 0; o < NO; o++)
        check($sformatf("vec%0d_out%0d", k, o), get_out(d, o), tbl[k].e[o]);
      if (k == 0) begin
        check("addr_seq_len", rd_log.size(), 8);
        for (int j = 0; j < 8 && j < rd_log.size(); j++)
          check($sformatf("addr_seq%0d", j), rd_log[j], ((j < 4) ? j + 1 : j + 3) * 16 + j);
      end
    end

    // start while busy, with new data presented: ignored
    load(0);
    run(0, 3, dc, nd);
    check("busy_start_done_cycle", dc, 13);
    check("busy_start_done_count", nd, 1);
    for (int o = 0; o < NO; o++)
      check($sformatf("busy_start_out%0d", o), get_out(0, o), tbl[0].e[o]);

    // start held high through DONE: re-accepted one cycle after done
    load(0);
    first = -1; second = -1; nd = 0;
    @(negedge clk);
    start[0] = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (bus0.done) begin
        nd++;
        if (first < 0) first = n; else second = n;
      end
      if (n == 13) check("hold_ov13", 32'(bus0.out_valid), 1);
      if (n == 14) begin
        check("hold_busy14", 32'(bus0.busy), 0);
        check("hold_ov14", 32'(bus0.out_valid), 1);
      end
      if (n == 15) begin
        check("hold_busy15", 32'(bus0.busy), 1);
        check("hold_ov15", 32'(bus0.out_valid), 0);
        start[0] = 1'b0;
      end
    end
    check("hold_first_done", first, 13);
    check("hold_second_done", second, 27);
    check("hold_done_count", nd, 2);
    for (int o = 0; o < NO; o++)
      check($sformatf("hold_out%0d", o), get_out(0, o), tbl[0].e[o]);

    // asynchronous reset mid-inference, then a clean run
    for (int t = 0; t < 2; t++) begin
      cyc = (t == 0) ? 6 : 8;
      load(4);
      @(negedge clk);
      start[0] = 1'b1;
      for (int n = 1; n <= cyc; n++) begin
        @(negedge clk);
        start[0] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_zero($sformatf("rst_mid_c%0d", cyc));
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 0, dc, nd);
      check($sformatf("after_rst%0d_done_cycle", t), dc, 13);
      for (int o = 0; o < NO; o++)
        check($sformatf("after_rst%0d_out%0d", t, o), get_out(0, o), tbl[4].e[o]);
    end

    // randomized runs against the reference model
    for (int r = 0; r < 8; r++) begin
      d = (r % 2 == 0) ? 0 : 2;
      for (int i = 0; i < NI; i++)
        flat[d][i] = (r < 4) ? int'($urandom_range(2000, 0)) - 1000 : $urandom;
      for (int i = 0; i < NW; i++)
        wmem[d][i] = (r < 4) ? int'($urandom_range(2000, 0)) - 1000 : $urandom;
      for (int i = 0; i < NO; i++)
        bias[d][i] = (r < 4) ? int'($urandom_range(200000, 0)) - 100000 : $urandom;
      for (int o = 0; o < NO; o++) exp_q.push_back(model(d, o));
      run(d, 0, dc, nd);
      check($sformatf("rand%0d_done_cycle", r), dc, 13);
      for (int o = 0; o < NO; o++)
        check($sformatf("rand%0d_out%0d", r, o), get_out(d, o), exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
